mcctrl: RTL
===========

MCCTRL -- requirements
Module: mcctrl

Interface
REQ-001 Parameter TIMEOUT, default 15: the number of consecutive cycles the block waits for mem_ack before it moves to ERROR.
REQ-002 clk  in  1  the single clock; every state change happens on its rising edge.
REQ-003 reset  in  1  asynchronous, active-low reset.
REQ-004 opcode  in  11  instruction bits [31:21], taken from the instruction register.
REQ-005 zero  in  1  ALU zero flag.
REQ-006 mem_ack  in  1  memory completion for the current request.
REQ-007 mem_req  out  1  memory request; held high until mem_ack is seen.
REQ-008 mem_we  out  1  memory write qualifier.
REQ-009 iord  out  1  memory address select: 0 = PC, 1 = ALU result.
REQ-010 irwrite, pcwrite, regwrite, flagwrite  out  1 each  register write strobes.
REQ-011 pcsrc  out  1  PC source select: 0 = PC+4, 1 = branch target.
REQ-012 memtoreg, reg2loc  out  1 each  datapath mux selects.
REQ-013 alusrc  out  2  ALU B-input select: 00 = register, 01 = sign-extended immediate, 10 = constant 4.
REQ-014 aluop  out  2  ALU operation class sent to the ALU control decoder: 00 = add, 01 = pass/compare B, 10 = funct-decoded.
REQ-015 state  out  4  current state encoding, for debug.
REQ-016 illegal  out  1  high while the block is in ERROR.

Function
REQ-017 Decode SHALL use the following encodings.
- R-group, exact 11-bit match: ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000, ADDS 10101011000, SUBS 11101011000.
- I-group, matched on opcode[10:1]: ADDI 1001000100, SUBI 1101000100, ADDIS 1011000100, SUBIS 1111000100.
- LDUR 11111000010 and STUR 11111000000, exact match.
- CBZ: opcode[10:3] = 10110100.
- B: opcode[10:5] = 000101.
REQ-018 The block SHALL be a Moore FSM with states FETCH, DECODE, EXEC, ALUWB, MEMADDR, MEMRD, MEMWB, MEMWR, BRANCH and ERROR; all outputs not listed for a state are 0.
REQ-019 FETCH: mem_req=1 and iord=0; on mem_ack, assert irwrite=1, pcwrite=1, pcsrc=0, alusrc=10, aluop=00 and go to DECODE; otherwise stay in FETCH.
REQ-020 DECODE: R-group or I-group goes to EXEC; LDUR or STUR goes to MEMADDR; CBZ or B goes to BRANCH; any other opcode goes to ERROR.
REQ-021 EXEC: aluop=10; alusrc=00 for the R-group and 01 for the I-group; flagwrite=1 only for ADDS, SUBS, ADDIS and SUBIS; next state ALUWB.
REQ-022 ALUWB: regwrite=1, memtoreg=0; next state FETCH.
REQ-023 MEMADDR: aluop=00, alusrc=01; next state MEMRD for LDUR, MEMWR for STUR.
REQ-024 MEMRD: mem_req=1, iord=1; on mem_ack go to MEMWB. MEMWB: regwrite=1, memtoreg=1; next state FETCH.
REQ-025 MEMWR: mem_req=1, mem_we=1, iord=1, reg2loc=1; on mem_ack go to FETCH.
REQ-026 BRANCH: aluop=01, reg2loc=1, pcsrc=1; pcwrite=1 for B, and for CBZ only when zero=1; next state FETCH.
REQ-027 ERROR: illegal=1 and all strobes 0; the block stays in ERROR until reset.
REQ-028 Wait counter behaviour:
- Counts cycles with mem_req=1 and mem_ack=0.
- Clears on mem_ack and on every state change.
- When the count reaches TIMEOUT without mem_ack, the next state is ERROR.
REQ-029 mem_ack SHALL be ignored in any state that is not requesting memory.
REQ-030 Cycle counts with mem_ack returned in the first cycle of each request:
- R-type and I-type: 4 cycles.
- LDUR: 5 cycles.
- STUR: 4 cycles.
- CBZ and B: 3 cycles.
REQ-031 Opcode matching SHALL use opcode as sampled in DECODE and MEMADDR; the block holds no copy of the instruction.

Reset
REQ-032 While reset=0, the block SHALL be in FETCH with the wait counter cleared and illegal=0, and every output except state SHALL be forced to 0 asynchronously.
REQ-033 Asserting reset mid-transaction SHALL drop mem_req in the same cycle and abandon the instruction; the first request after release is a FETCH with iord=0.

Configuration
REQ-034 When MCCTRL_PERF_EN is defined, the block SHALL add two outputs:
- cycles[31:0]: counts every clock cycle with reset=1.
- instret[31:0]: increments on each transition into FETCH from ALUWB, MEMWB, MEMWR or BRANCH.
- Both counters clear on reset and wrap modulo 2^32.
REQ-035 When MCCTRL_PERF_EN is undefined, those ports and counters SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-036 ADD opcode, mem_ack on the first FETCH cycle -> states FETCH, DECODE, EXEC, ALUWB; in EXEC aluop=10 and alusrc=00; regwrite=1 for exactly one cycle; back in FETCH on cycle 5.
REQ-037 LDUR with mem_ack delayed 3 cycles in MEMRD -> mem_req=1 and iord=1 for 4 cycles; then MEMWB with regwrite=1 and memtoreg=1.
REQ-038 CBZ with zero=1, then CBZ with zero=0, then B -> pcwrite=1 in BRANCH for the first and third, pcwrite=0 for the second; pcsrc=1 in all three.
REQ-039 Opcode 00000000000 in DECODE -> ERROR with illegal=1; a later mem_ack has no effect; reset=0 returns the block to FETCH.
REQ-040 mem_ack withheld in FETCH -> after TIMEOUT (15) wait cycles the block enters ERROR. Separately, reset pulsed low during MEMWR -> mem_req=0 immediately.
REQ-041 MCCTRL_PERF_EN defined, sequence ADDI, STUR, B -> instret=3 once all three have completed.

Source files
------------

// File: rtl/mcctrl.sv
// mcctrl: multicycle LEGv8 control FSM with a memory-handshake timeout.
// Define MCCTRL_PERF_EN to add the cycles/instret performance counters.
module mcctrl #(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [10:0] opcode,
  input  logic        zero,
  input  logic        mem_ack,
  output logic        mem_req,
  output logic        mem_we,
  output logic        iord,
  output logic        irwrite,
  output logic        pcwrite,
  output logic        regwrite,
  output logic        flagwrite,
  output logic        pcsrc,
  output logic        memtoreg,
  output logic        reg2loc,
  output logic [1:0]  alusrc,
  output logic [1:0]  aluop,
  output logic [3:0]  state,
  output logic        illegal
`ifdef MCCTRL_PERF_EN
  ,
  output logic [31:0] cycles,
  output logic [31:0] instret
`endif
);
  typedef enum logic [3:0] {
    FETCH, DECODE, EXEC, ALUWB, MEMADDR, MEMRD, MEMWB, MEMWR, BRANCH, ERROR
  } state_t;
  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       iord;
    logic       irwrite;
    logic       pcwrite;
    logic       regwrite;
    logic       flagwrite;
    logic       pcsrc;
    logic       memtoreg;
    logic       reg2loc;
    logic [1:0] alusrc;
    logic [1:0] aluop;
    logic       illegal;
  } ctl_t;
  localparam int CW = $clog2(TIMEOUT + 1);
  state_t cur, nxt;
  ctl_t c;
  logic [CW-1:0] cnt;
  logic is_r, is_i, is_ld, is_st, is_cbz, is_b, is_flag, waiting, expired;
  assign is_r = opcode inside {11'b10001011000, 11'b11001011000, 11'b10001010000,
                               11'b10101010000, 11'b10101011000, 11'b11101011000};
  assign is_i = opcode[10:1] inside {10'b1001000100, 10'b1101000100, 10'b1011000100, 10'b1111000100};
  assign is_ld = opcode == 11'b11111000010;
  assign is_st = opcode == 11'b11111000000;
  assign is_cbz = opcode[10:3] == 8'b10110100;
  assign is_b = opcode[10:5] == 6'b000101;
  assign is_flag = opcode inside {11'b10101011000, 11'b11101011000} ||
                   opcode[10:1] inside {10'b1011000100, 10'b1111000100};
  // only the three requesting states can wait on memory
  assign waiting = (cur inside {FETCH, MEMRD, MEMWR}) && !mem_ack;
  assign expired = waiting && cnt == CW'(TIMEOUT - 1);
  always_comb begin
    nxt = cur;
    c = '0;
    unique case (cur)
      FETCH: begin
        c.mem_req = 1'b1;
        if (mem_ack) begin
          c.irwrite = 1'b1;
          c.pcwrite = 1'b1;
          c.alusrc = 2'b10;
          nxt = DECODE;
        end
      end
      DECODE: nxt = (is_r || is_i) ? EXEC : (is_ld || is_st) ? MEMADDR : (is_cbz || is_b) ? BRANCH : ERROR;
      EXEC: begin
        c.aluop = 2'b10;
        c.alusrc = is_i ? 2'b01 : 2'b00;
        c.flagwrite = is_flag;
        nxt = ALUWB;
      end
      ALUWB: begin
        c.regwrite = 1'b1;
        nxt = FETCH;
      end
      MEMADDR: begin
        c.alusrc = 2'b01;
        nxt = is_st ? MEMWR : MEMRD;
      end
      MEMRD: begin
        c.mem_req = 1'b1;
        c.iord = 1'b1;
        if (mem_ack) nxt = MEMWB;
      end
      MEMWB: begin
        c.regwrite = 1'b1;
        c.memtoreg = 1'b1;
        nxt = FETCH;
      end
      MEMWR: begin
        c.mem_req = 1'b1;
        c.mem_we = 1'b1;
        c.iord = 1'b1;
        c.reg2loc = 1'b1;
        if (mem_ack) nxt = FETCH;
      end
      BRANCH: begin
        c.aluop = 2'b01;
        c.reg2loc = 1'b1;
        c.pcsrc = 1'b1;
        c.pcwrite = is_b || (is_cbz && zero);
        nxt = FETCH;
      end
      ERROR: c.illegal = 1'b1;
      default: nxt = ERROR;
    endcase
    if (expired) nxt = ERROR;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      cur <= FETCH;
      cnt <= '0;
    end else begin
      cur <= nxt;
      cnt <= (nxt != cur || !waiting) ? '0 : cnt + 1'b1;
    end
  assign state = cur;
  // outputs are forced low asynchronously while reset is held
  assign {mem_req, mem_we, iord, irwrite, pcwrite, regwrite, flagwrite, pcsrc,
          memtoreg, reg2loc, alusrc, aluop, illegal} = reset ? c : '0;
`ifdef MCCTRL_PERF_EN
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      cycles <= '0;
      instret <= '0;
    end else begin
      cycles <= cycles + 1'b1;
      if (nxt == FETCH && cur inside {ALUWB, MEMWB, MEMWR, BRANCH}) instret <= instret + 1'b1;
    end
`endif
endmodule
